// File: rtl/tx_rs_layer_if.sv
// MAC-side word bus and PHY-side XGMII lanes of the transmit reconciliation sublayer.
// The slave modport is the RS block; the master modport is the MAC/PHY environment.
interface tx_rs_layer_if;
    logic [63:0] txd64;
    logic [7:0]  txc8;
    logic        tx_rd;
    logic [31:0] txd;
    logic [3:0]  txc;

    modport master (
        output txd64,
        output txc8,
        input  tx_rd,
        input  txd,
        input  txc
    );

    modport slave (
        input  txd64,
        input  txc8,
        output tx_rd,
        output txd,
        output txc
    );
endinterface

// File: rtl/tx_rs_layer.sv
// Transmit reconciliation sublayer: splits 64-bit MAC words into 32-bit XGMII transfers
// and substitutes Remote Fault / Idle columns at frame boundaries while a link fault is reported.
module tx_rs_layer #(
    parameter int unsigned MIN_HOLD = 4
) (
    input  logic         txclk_2x,
    input  logic         reset,
    input  logic [1:0]   link_fault,
    tx_rs_layer_if.slave bus
);
    localparam logic [63:0] IDLE_D    = 64'h07070707_07070707;
    localparam logic [7:0]  IDLE_C    = 8'hFF;
    localparam logic [63:0] RF_D      = 64'h0200009C_0200009C;
    localparam logic [7:0]  RF_C      = 8'h11;
    localparam logic [3:0]  HOLD_INIT = 4'(MIN_HOLD - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_OVR   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic        rf_q, rf_d;
    logic        tx_rd_q;
    logic [31:0] hold_hi_q;
    logic [3:0]  hold_hic_q;
    logic [31:0] txd_q;
    logic [3:0]  txc_q;

    logic [7:0]  term_s;
    logic [7:0]  idle_lane_s;
    logic        start0_s, start4_s, start_any_s;
    logic        term_lo_s, term_any_s, pure_idle_s;
    logic        fault_s, lf_rf_s;
    logic        repl_s, repl_rf_s;
    logic [63:0] word_d;
    logic [7:0]  ctl_d;

    // Per-lane decode of Terminate/Error and Idle control characters in the offered word
    always_comb begin
        term_s      = 8'd0;
        idle_lane_s = 8'd0;
        for (int n = 0; n < 8; n++) begin
            term_s[n]      = bus.txc8[n] && ((bus.txd64[8*n +: 8] == 8'hFD) ||
                                             (bus.txd64[8*n +: 8] == 8'hFE));
            idle_lane_s[n] = bus.txc8[n] && (bus.txd64[8*n +: 8] == 8'h07);
        end
    end

    assign start0_s    = bus.txc8[0] && (bus.txd64[7:0] == 8'hFB);
    assign start4_s    = bus.txc8[4] && (bus.txd64[39:32] == 8'hFB);
    assign start_any_s = start0_s || start4_s;
    assign term_lo_s   = |term_s[3:0];
    assign term_any_s  = |term_s;
    assign pure_idle_s = &idle_lane_s;
    // 01 and 11 both count as local fault and are answered with Remote Fault
    assign fault_s     = (link_fault != 2'b00);
    assign lf_rf_s     = link_fault[0];

    // Per-word next state and the word actually forwarded to the PHY
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rf_d      = rf_q;
        repl_s    = 1'b0;
        repl_rf_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fault_s && !start_any_s) begin
                    state_d   = ST_OVR;
                    hold_d    = HOLD_INIT;
                    rf_d      = lf_rf_s;
                    repl_s    = 1'b1;
                    repl_rf_s = lf_rf_s;
                end else if (start4_s || (start0_s && !term_any_s)) begin
                    state_d = ST_FRAME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FRAME: begin
                // A lane-4 Start behind a low-half Terminate opens the next frame
                if (start4_s && term_lo_s) begin
                    state_d = ST_FRAME;
                end else if (term_any_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FRAME;
                end
            end
            ST_OVR: begin
                hold_d = (hold_q == 4'd0) ? 4'd0 : (hold_q - 4'd1);
                if ((hold_q == 4'd0) && !fault_s) begin
                    if (pure_idle_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        repl_s    = 1'b1;
                        repl_rf_s = 1'b0;
                    end
                end else begin
                    // While the hold runs out with no fault, keep the last fault content
                    rf_d      = fault_s ? lf_rf_s : rf_q;
                    repl_s    = 1'b1;
                    repl_rf_s = rf_d;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                hold_d    = 4'd0;
                rf_d      = 1'b0;
                repl_s    = 1'b1;
                repl_rf_s = 1'b0;
            end
        endcase

        if (repl_s) begin
            word_d = repl_rf_s ? RF_D : IDLE_D;
            ctl_d  = repl_rf_s ? RF_C : IDLE_C;
        end else begin
            word_d = bus.txd64;
            ctl_d  = bus.txc8;
        end
    end

    // Word-rate FSM and double-rate serializer; phase-0 edges sample, phase-1 edges send the high half
    always_ff @(posedge txclk_2x or negedge reset) begin
        if (!reset) begin
            tx_rd_q    <= 1'b1;
            state_q    <= ST_IDLE;
            hold_q     <= 4'd0;
            rf_q       <= 1'b0;
            hold_hi_q  <= IDLE_D[63:32];
            hold_hic_q <= IDLE_C[7:4];
            txd_q      <= IDLE_D[31:0];
            txc_q      <= IDLE_C[3:0];
        end else begin
            tx_rd_q <= ~tx_rd_q;
            if (tx_rd_q) begin
                state_q    <= state_d;
                hold_q     <= hold_d;
                rf_q       <= rf_d;
                hold_hi_q  <= word_d[63:32];
                hold_hic_q <= ctl_d[7:4];
                txd_q      <= word_d[31:0];
                txc_q      <= ctl_d[3:0];
            end else begin
                txd_q <= hold_hi_q;
                txc_q <= hold_hic_q;
            end
        end
    end

    assign bus.tx_rd = tx_rd_q;
    assign bus.txd   = txd_q;
    assign bus.txc   = txc_q;
endmodule

// File: tb/tb_tx_rs_layer.sv
// Scoreboard bench for tx_rs_layer: directed 64-bit words with hand-written expected XGMII halves.
module tb_tx_rs_layer;
    localparam logic [63:0] IDL  = 64'h07070707_07070707;
    localparam logic [7:0]  IDC  = 8'hFF;
    localparam logic [63:0] RFD  = 64'h0200009C_0200009C;
    localparam logic [7:0]  RFC  = 8'h11;
    localparam logic [63:0] SOF  = 64'hD5555555_555555FB;
    localparam logic [7:0]  SOFC = 8'h01;
    localparam logic [63:0] DAT  = 64'h0A0B0C0D_01020304;
    localparam logic [7:0]  DATC = 8'h00;
    localparam logic [63:0] EOF  = 64'h070707FD_11223344;
    localparam logic [7:0]  EOFC = 8'hF0;
    localparam logic [63:0] S4   = 64'hD55555FB_070707FD;
    localparam logic [7:0]  S4C  = 8'h1F;

    logic       txclk_2x = 1'b0;
    logic       reset;
    logic [1:0] link_fault;

    tx_rs_layer_if bus ();

    tx_rs_layer #(.MIN_HOLD(4)) dut (
        .txclk_2x  (txclk_2x),
        .reset     (reset),
        .link_fault(link_fault),
        .bus       (bus)
    );

    always #5 txclk_2x = ~txclk_2x;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b1;
    bit   have_low = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: low half is visible while tx_rd is low, high half on the following cycle
    always @(negedge txclk_2x) begin
        if (!reset) begin
            sb.delete();
            have_low = 1'b0;
        end else if (mon_en) begin
            if (bus.tx_rd == 1'b0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h/%h with empty scoreboard", bus.txd, bus.txc);
                end else begin
                    check({sb[0].name, "_lo"}, {28'd0, bus.txd, bus.txc},
                          {28'd0, sb[0].d[31:0], sb[0].c[3:0]});
                    have_low = 1'b1;
                end
            end else if (have_low) begin
                check({sb[0].name, "_hi"}, {28'd0, bus.txd, bus.txc},
                      {28'd0, sb[0].d[63:32], sb[0].c[7:4]});
                void'(sb.pop_front());
                have_low = 1'b0;
            end
        end
    end

    task automatic drive_word(input logic [63:0] din, input logic [7:0] cin, input logic [1:0] lf,
                              input logic [63:0] ed, input logic [7:0] ec, input string name);
        bus.txd64  = din;
        bus.txc8   = cin;
        link_fault = lf;
        sb.push_back('{ed, ec, name});
    endtask

    task automatic send_word(input logic [63:0] din, input logic [7:0] cin, input logic [1:0] lf,
                             input logic [63:0] ed, input logic [7:0] ec, input string name);
        int g;
        g = 0;
        @(negedge txclk_2x);
        while (bus.tx_rd !== 1'b1 && g < 4) begin
            @(negedge txclk_2x);
            g++;
        end
        if (g >= 4) begin
            total++;
            bad++;
            $display("FAIL tx_rd_timeout: got %b expected 1", bus.tx_rd);
        end
        drive_word(din, cin, lf, ed, ec, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        link_fault = 2'b00;
        bus.txd64  = IDL;
        bus.txc8   = IDC;
        #12;
        check("reset_txd", {32'd0, bus.txd}, {32'd0, 32'h07070707});
        check("reset_txc", {60'd0, bus.txc}, {60'd0, 4'hF});
        check("reset_tx_rd", {63'd0, bus.tx_rd}, 64'd1);
        @(negedge txclk_2x);
        #1;
        reset = 1'b1;
        drive_word(IDL, IDC, 2'b00, IDL, IDC, "idle_first");
        check("rel_tx_rd_1", {63'd0, bus.tx_rd}, 64'd1);
        @(negedge txclk_2x);
        check("rel_tx_rd_0", {63'd0, bus.tx_rd}, 64'd0);
        @(negedge txclk_2x);
        check("rel_tx_rd_1b", {63'd0, bus.tx_rd}, 64'd1);
        drive_word(IDL, IDC, 2'b00, IDL, IDC, "idle_second");
        send_word(IDL, IDC, 2'b00, IDL, IDC, "idle_third");

        // Link OK frame passes unchanged
        send_word(SOF, SOFC, 2'b00, SOF, SOFC, "frm_sof");
        send_word(DAT, DATC, 2'b00, DAT, DATC, "frm_dat");
        send_word(EOF, EOFC, 2'b00, EOF, EOFC, "frm_eof");
        send_word(IDL, IDC, 2'b00, IDL, IDC, "frm_idle");

        // Local fault in IDLE: Remote Fault for MIN_HOLD words, then pass-through
        send_word(IDL, IDC, 2'b01, RFD, RFC, "lf_entry");
        for (int i = 0; i < 3; i++) send_word(IDL, IDC, 2'b00, RFD, RFC, "lf_hold");
        send_word(IDL, IDC, 2'b00, IDL, IDC, "lf_exit");
        send_word(IDL, IDC, 2'b00, IDL, IDC, "lf_after");

        // Exit blocked by a MAC frame: whole frame replaced by Idle, exit on pure Idle
        send_word(IDL, IDC, 2'b01, RFD, RFC, "rt_entry");
        for (int i = 0; i < 3; i++) send_word(IDL, IDC, 2'b00, RFD, RFC, "rt_hold");
        send_word(SOF, SOFC, 2'b00, IDL, IDC, "rt_sof");
        send_word(DAT, DATC, 2'b00, IDL, IDC, "rt_dat");
        send_word(EOF, EOFC, 2'b00, IDL, IDC, "rt_eof");
        send_word(IDL, IDC, 2'b00, IDL, IDC, "rt_exit");
        send_word(SOF, SOFC, 2'b00, SOF, SOFC, "rt_sof_pass");
        send_word(EOF, EOFC, 2'b00, EOF, EOFC, "rt_eof_pass");

        // Fault arrives mid-frame: 5-word frame intact, Remote Fault after Terminate
        send_word(SOF, SOFC, 2'b00, SOF, SOFC, "mf_sof");
        send_word(DAT, DATC, 2'b01, DAT, DATC, "mf_dat1");
        send_word(DAT, DATC, 2'b01, DAT, DATC, "mf_dat2");
        send_word(DAT, DATC, 2'b01, DAT, DATC, "mf_dat3");
        send_word(EOF, EOFC, 2'b01, EOF, EOFC, "mf_eof");
        send_word(IDL, IDC, 2'b01, RFD, RFC, "mf_rf");
        for (int i = 0; i < 3; i++) send_word(IDL, IDC, 2'b00, RFD, RFC, "mf_hold");
        send_word(IDL, IDC, 2'b00, IDL, IDC, "mf_exit");

        // Terminate in lanes 0-3 with Start in lane 4 keeps the frame open
        send_word(SOF, SOFC, 2'b00, SOF, SOFC, "s4_sof");
        send_word(S4, S4C, 2'b00, S4, S4C, "s4_word");
        send_word(DAT, DATC, 2'b01, DAT, DATC, "s4_dat");
        send_word(EOF, EOFC, 2'b01, EOF, EOFC, "s4_eof");
        send_word(IDL, IDC, 2'b01, RFD, RFC, "s4_rf");
        for (int i = 0; i < 3; i++) send_word(IDL, IDC, 2'b00, RFD, RFC, "s4_hold");
        send_word(IDL, IDC, 2'b00, IDL, IDC, "s4_exit");

        // Remote fault: Idle override swallows a whole MAC frame; 11 acts as local fault
        send_word(IDL, IDC, 2'b10, IDL, IDC, "rm_entry");
        send_word(SOF, SOFC, 2'b10, IDL, IDC, "rm_sof");
        send_word(DAT, DATC, 2'b10, IDL, IDC, "rm_dat");
        send_word(EOF, EOFC, 2'b10, IDL, IDC, "rm_eof");
        send_word(IDL, IDC, 2'b11, RFD, RFC, "rm_lf11");
        send_word(IDL, IDC, 2'b00, IDL, IDC, "rm_exit");

        // Reset during the low-half cycle of a Start word
        send_word(SOF, SOFC, 2'b00, SOF, SOFC, "rst_sof");
        @(posedge txclk_2x);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_txd", {32'd0, bus.txd}, {32'd0, 32'h07070707});
        check("rst_mid_txc", {60'd0, bus.txc}, {60'd0, 4'hF});
        check("rst_mid_tx_rd", {63'd0, bus.tx_rd}, 64'd1);
        repeat (3) @(negedge txclk_2x);
        #1;
        reset = 1'b1;
        drive_word(IDL, IDC, 2'b01, RFD, RFC, "rst_rf_entry");
        check("rst_rel_tx_rd", {63'd0, bus.tx_rd}, 64'd1);
        for (int i = 0; i < 3; i++) send_word(IDL, IDC, 2'b00, RFD, RFC, "rst_hold");
        send_word(IDL, IDC, 2'b00, IDL, IDC, "rst_exit");

        repeat (2) @(negedge txclk_2x);
        #1;
        mon_en = 1'b0;
        check("sb_drained", {32'd0, 32'(sb.size())}, 64'd0);
        check("no_half_word", {63'd0, have_low}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
